ps2_kbd_rx_fifo: RTL
====================

# ps2_kbd_rx_fifo

Parametrised PS/2 keyboard receiver with a buffered, interrupt-driven CPU interface. It replaces the single-byte keyboard path. Scan codes from the keyboard are synchronised, glitch-filtered, framed and parity-checked, then queued in a FIFO. The CPU drains the FIFO through a `cpu_intr`/`cpu_ack` handshake. When the FIFO is full, the block holds the PS/2 clock low (host inhibit) so the keyboard buffers its own keystrokes instead of losing them.

## Interface
- `FIFO_DEPTH`, default 8: number of queued scan codes; power of two, ≥2.
- `FILTER_LEN`, default 4: consecutive equal samples needed before the filtered PS/2 clock changes.
- `TIMEOUT_CYCLES`, default 20000: idle `clk` cycles allowed between bits within a frame before the frame is abandoned.

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `ps2_data`  in  1: PS/2 data pin, asynchronous.
- `ps2_clk`  in  1: PS/2 clock pin, asynchronous.
- `cpu_ack`  in  1: CPU acknowledge, synchronous to `clk`.
- `cpu_intr`  out  1: interrupt request; a code is available.
- `code_out`  out  8: scan code at the FIFO head.
- `ps2_clk_pulldown`  out  1: drives the PS/2 clock low (inhibit).
- `ps2_data_pulldown`  out  1: always 0 (receive-only block).
- `frame_err`  out  1: one-cycle pulse on a dropped frame.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- **Input conditioning**
  - Both pins pass through a 2-FF synchroniser.
  - The filtered clock toggles only after `FILTER_LEN` equal consecutive synchronised samples.
  - A falling edge of the filtered clock produces a one-cycle `bit_stb`.
  - Data is sampled from the synchronised `ps2_data` on `bit_stb`.
- **Frame format:** 11 bits — start (0), 8 data bits LSB first, odd parity, stop (1).
- **Receiver FSM:** IDLE → DATA (8 bits, 3-bit counter) → PARITY → STOP → IDLE.
  - IDLE: a sampled start bit of 1 is ignored; the FSM stays in IDLE with no error.
  - STOP: the byte is pushed if parity is odd over data+parity and stop == 1. Otherwise `frame_err` pulses and the byte is discarded.
  - Timeout: in any non-IDLE state, a counter reloads on `bit_stb`. Reaching `TIMEOUT_CYCLES` returns the FSM to IDLE and pulses `frame_err`.
- **FIFO:** circular buffer with a `$clog2(FIFO_DEPTH)`-bit read and write pointer that wrap naturally.
  - A push while full discards the byte and pulses `frame_err`. This can only occur if the keyboard ignores the inhibit.
  - Simultaneous push and pop leaves `fifo_count` unchanged; both pointers advance.
- **CPU handshake**
  - `code_out` always shows the FIFO head; it is 0x00 when empty.
  - `cpu_intr` = FIFO non-empty AND not `ack_pending`.
  - A pop occurs on the rising edge of `cpu_ack` (`cpu_ack` high, previous `cpu_ack` low) while `cpu_intr` is high. The pop sets `ack_pending`.
  - `ack_pending` clears when `cpu_ack` returns low. `cpu_intr` then reasserts if more codes remain.
  - Holding `cpu_ack` high never pops more than once.
- **Inhibit:** `ps2_clk_pulldown` is set when `fifo_count == FIFO_DEPTH` and the FSM is IDLE. It is cleared when `fifo_count` drops below `FIFO_DEPTH`. An in-progress frame is never cut.
- **Reset values:** all outputs 0, FIFO empty, FSM IDLE, filtered clock 1, `ack_pending` 0.
  - Reset mid-frame discards the partial frame.
  - Bits arriving after reset mid-frame are resolved by the start-bit check or the timeout.

## Timing
- A pin falling edge produces `bit_stb` 2 + `FILTER_LEN` cycles later, given a clean edge.
- If `bit_stb` for the stop bit occurs in cycle N:
  - the FIFO write happens at the N+1 edge;
  - `fifo_count`, `code_out` (if the FIFO was empty) and `cpu_intr` are valid from cycle N+1.
- `frame_err` is high for exactly cycle N+1 on a parity or stop error, and for the cycle after expiry on a timeout.
- If `cpu_ack` rises in cycle M:
  - `cpu_intr` goes low from M+1;
  - `code_out` shows the next entry from M+1.
- `ps2_clk_pulldown` is registered. It asserts the cycle after the full condition is met in IDLE and releases the cycle after the pop.

## Structure
- Package `ps2_pkg` holds:
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - `PS2_DATA_BITS` = 8;
  - the odd-parity function.
- Sub-module `ps2_sync_filter` contains the 2-FF sync, the `FILTER_LEN` filter and the falling-edge detect. It outputs the filtered clock, the synchronised data and `bit_stb`.
- The FIFO, FSM, handshake and inhibit logic live in the top of this block.

## Test plan
- Send frame 0x1C (data 0,0,1,1,1,0,0,0; parity 0; stop 1) -> `fifo_count`=1, `code_out`=0x1C, `cpu_intr`=1. Pulse `cpu_ack` -> `cpu_intr`=0, count 0.
- Send 0x1C with parity 1 -> `frame_err` one cycle, `cpu_intr` stays 0. A following 0xF0 frame (parity 1) is queued correctly.
- Send 8 codes 0x01..0x08 with no ack -> count 8, `ps2_clk_pulldown`=1. One ack -> `code_out`=0x02, count 7, pulldown 0 next cycle.
- With `cpu_ack` held high for 10 cycles while 3 codes are queued -> exactly one pop. Lower and raise `cpu_ack` -> second pop.
- Inject a 2-cycle low glitch on `ps2_clk` (`FILTER_LEN`=4) -> no `bit_stb`, FSM stays IDLE. Send 5 bits then go silent -> `frame_err` after `TIMEOUT_CYCLES`, then a clean 0x5A is received.
- Assert `rst` after 6 bits of a frame -> all outputs 0, count 0. The remaining bits cause no push, and the next full frame is received.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard receive path.
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  // Receiver frame states: start bit is consumed in IDLE, then data, parity, stop.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // True when data plus parity together hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 pin conditioning: 2-FF synchronisers, clock glitch filter and a
// one-cycle strobe on each falling edge of the filtered clock.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_filt,
  output logic data_sync,
  output logic bit_stb
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          filt_reg;
  logic          stb_reg;

  // Two-stage synchronisers; both pins idle high on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples;
  // the strobe fires on the same edge when the flip is high-to-low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      filt_reg <= 1'b1;
      stb_reg  <= 1'b0;
    end else begin
      stb_reg <= 1'b0;
      if (clk_sync_reg[1] == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
        filt_reg <= clk_sync_reg[1];
        cnt_reg  <= '0;
        stb_reg  <= filt_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign clk_filt  = filt_reg;
  assign data_sync = data_sync_reg[1];
  assign bit_stb   = stb_reg;

endmodule

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: frames and checks scan codes, queues them in a FIFO,
// hands them to the CPU via an intr/ack handshake and inhibits the keyboard
// clock while the queue is full.
module ps2_kbd_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_data,
  input  logic                        ps2_clk,
  input  logic                        cpu_ack,
  output logic                        cpu_intr,
  output logic [7:0]                  code_out,
  output logic                        ps2_clk_pulldown,
  output logic                        ps2_data_pulldown,
  output logic                        frame_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  import ps2_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Conditioned pins
  logic filt_clk_unused;
  logic data_sync;
  logic bit_stb;

  // Receiver
  rx_state_t                state_reg;
  logic [2:0]               bit_cnt_reg;
  logic [PS2_DATA_BITS-1:0] shift_reg;
  logic                     parity_reg;
  logic [TW-1:0]            to_cnt_reg;
  logic                     frame_err_reg;

  // FIFO
  logic [PS2_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_reg;
  logic [AW-1:0]            rd_ptr_reg;
  logic [CW-1:0]            count_reg;

  // Handshake / inhibit
  logic ack_prev_reg;
  logic ack_pending_reg;
  logic pulldown_reg;

  logic stop_seen;
  logic frame_good;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic wr_en;
  logic drop;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clk_filt  (filt_clk_unused),
    .data_sync (data_sync),
    .bit_stb   (bit_stb)
  );

  assign stop_seen  = bit_stb && (state_reg == STOP);
  assign frame_good = odd_parity_ok(shift_reg, parity_reg) && data_sync;
  assign push       = stop_seen && frame_good;

  assign full  = (count_reg == CW'(FIFO_DEPTH));
  assign empty = (count_reg == '0);

  assign cpu_intr = !empty && !ack_pending_reg;
  assign pop      = cpu_ack && !ack_prev_reg && cpu_intr;

  // A simultaneous pop frees the head slot, so a push into a full queue is
  // only lost when nothing leaves on the same edge.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // Frame receiver with inter-bit timeout; frame_err is a registered pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      to_cnt_reg    <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= drop;
      if (state_reg == IDLE) begin
        to_cnt_reg <= '0;
        // A high start bit is line noise or a stray bit after reset: ignore it.
        if (bit_stb && !data_sync) begin
          state_reg   <= DATA;
          bit_cnt_reg <= 3'd0;
        end
      end else if (bit_stb) begin
        to_cnt_reg <= '0;
        case (state_reg)
          DATA: begin
            shift_reg   <= {data_sync, shift_reg[PS2_DATA_BITS-1:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
          end
          PARITY: begin
            parity_reg <= data_sync;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            if (!frame_good) frame_err_reg <= 1'b1;
          end
          default: state_reg <= IDLE;
        endcase
      end else if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
        state_reg     <= IDLE;
        to_cnt_reg    <= '0;
        frame_err_reg <= 1'b1;
      end else begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= shift_reg;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Acknowledge edge detect; one pop per ack assertion, re-armed when ack drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_prev_reg    <= 1'b0;
      ack_pending_reg <= 1'b0;
    end else begin
      ack_prev_reg <= cpu_ack;
      if (pop)
        ack_pending_reg <= 1'b1;
      else if (!cpu_ack)
        ack_pending_reg <= 1'b0;
    end
  end

  // Clock inhibit: only start holding the bus between frames, release once room exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulldown_reg <= 1'b0;
    end else if (full && (state_reg == IDLE)) begin
      pulldown_reg <= 1'b1;
    end else if (!full) begin
      pulldown_reg <= 1'b0;
    end
  end

  assign code_out          = empty ? 8'h00 : mem[rd_ptr_reg];
  assign fifo_count        = count_reg;
  assign frame_err         = frame_err_reg;
  assign ps2_clk_pulldown  = pulldown_reg;
  assign ps2_data_pulldown = 1'b0;

endmodule
